// File: rtl/uart_rom_loader.sv
// uart_rom_loader: boot-time program loader for the instruction ROM.
// Receives a framed image over UART (8N1, LSB first) and writes it word by
// word into the ROM write port. The core is held in reset until the whole
// image has been written and its 8-bit checksum matches.
//
// Frame: 0xA5 | LEN_LO | LEN_HI | LEN x 32-bit words (little-endian) | CHK
// CHK is the mod-256 sum of the two LEN bytes and every data byte.
//
// Ports:
//   clk        system clock
//   rstn       synchronous active-low reset
//   uart_rx    asynchronous serial input, idles high
//   rom_we     ROM write strobe, one cycle per word
//   rom_waddr  ROM byte address (word aligned)
//   rom_wdata  ROM write data
//   core_rstn  active-low reset to the core, released after a good load
//   busy       frame reception in progress
//   load_done  image loaded and checksum OK (sticky until rstn)
//   load_err   frame or checksum error (cleared by the next sync byte)
module uart_rom_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          ROM_DEPTH    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_rx,
    output logic        rom_we,
    output logic [31:0] rom_waddr,
    output logic [31:0] rom_wdata,
    output logic        core_rstn,
    output logic        busy,
    output logic        load_done,
    output logic        load_err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    // One extra bit so that LEN == ROM_DEPTH still fits in the word index.
    localparam int IW = $clog2(ROM_DEPTH) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t     r_state, r_nx;
    logic          rx_s1, rx_s2, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          rx_valid, rx_ferr;
    logic          tick;

    // Start phase waits half a bit so later samples land mid-bit.
    assign tick = (r_state == R_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

    always_comb begin
        r_nx = r_state;
        case (r_state)
            R_IDLE:  if (rx_d && !rx_s2) r_nx = R_START;
            // Line back high at mid start bit means a glitch, not a byte.
            R_START: if (tick) r_nx = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (tick && bit_idx == 3'd7) r_nx = R_STOP;
            R_STOP:  if (tick) r_nx = R_IDLE;
            default: r_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            r_state  <= R_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            r_state  <= r_nx;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            cnt      <= (r_state == R_IDLE || tick) ? '0 : cnt + 1'b1;
            if (r_state == R_START) bit_idx <= '0;
            if (r_state == R_DATA && tick) begin
                sh      <= {rx_s2, sh[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (r_state == R_STOP && tick) begin
                rx_valid <= rx_s2;
                rx_ferr  <= !rx_s2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CHKS, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [15:0]   len;
    logic [15:0]   len_full;
    logic [IW-1:0] idx;
    logic [7:0]    sum;
    logic [23:0]   word;
    logic [1:0]    byte_cnt;
    logic          last_word;

    assign len_full  = {sh, len[7:0]};
    assign last_word = (32'(idx) + 32'd1) == {16'h0, len};

    always_comb begin
        state_nx = state;
        if (rx_ferr && state != S_SYNC && state != S_DONE) begin
            state_nx = S_ERR;
        end else if (rx_valid) begin
            case (state)
                S_SYNC, S_ERR: if (sh == 8'hA5) state_nx = S_LEN0;
                S_LEN0:        state_nx = S_LEN1;
                S_LEN1: begin
                    if ({16'h0, len_full} > 32'(ROM_DEPTH)) state_nx = S_ERR;
                    else if (len_full == 16'h0)             state_nx = S_CHKS;
                    else                                    state_nx = S_DATA;
                end
                S_DATA:        if (byte_cnt == 2'd3 && last_word) state_nx = S_CHKS;
                S_CHKS:        state_nx = (sh == sum) ? S_DONE : S_ERR;
                default:       state_nx = state;
            endcase
        end
    end

    assign busy      = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CHKS);
    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERR);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_SYNC;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            word      <= '0;
            byte_cnt  <= '0;
            rom_we    <= 1'b0;
            rom_waddr <= BASE_ADDR;
            rom_wdata <= '0;
            core_rstn <= 1'b0;
        end else begin
            state     <= state_nx;
            rom_we    <= 1'b0;
            // Registered from the state so the core sees release only
            // after DONE has been entered, never before.
            core_rstn <= (state == S_DONE);
            if (rx_valid) begin
                case (state)
                    S_SYNC, S_ERR: begin
                        if (sh == 8'hA5) begin
                            sum      <= '0;
                            idx      <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    S_LEN0: begin
                        len[7:0] <= sh;
                        sum      <= sum + sh;
                    end
                    S_LEN1: begin
                        len[15:8] <= sh;
                        sum       <= sum + sh;
                    end
                    S_DATA: begin
                        sum      <= sum + sh;
                        byte_cnt <= byte_cnt + 1'b1;
                        case (byte_cnt)
                            2'd0: word[7:0]   <= sh;
                            2'd1: word[15:8]  <= sh;
                            2'd2: word[23:16] <= sh;
                            default: begin
                                rom_we    <= 1'b1;
                                rom_wdata <= {sh, word};
                                rom_waddr <= BASE_ADDR + (32'(idx) << 2);
                                idx       <= idx + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
